// File: rtl/pio_pkg.sv
// Shared types and constants for the PIO FIFO pair.
// Holds the join-mode encoding, the debug flag bit positions and the join decode helper.
// Pure declarations: no logic, no latency, no flow control.
package pio_pkg;

  // Effective storage sharing mode between the TX and RX directions.
  typedef enum logic [1:0] {
    JOIN_NONE = 2'd0,
    JOIN_TX   = 2'd1,
    JOIN_RX   = 2'd2
  } join_mode_t;

  // Bit positions inside dbg_flags / dbg_clr: {rxstall, rxunder, txover, txstall}.
  localparam int DBG_TXSTALL = 0;
  localparam int DBG_TXOVER  = 1;
  localparam int DBG_RXUNDER = 2;
  localparam int DBG_RXSTALL = 3;

  // join_tx dominates: join_rx only matters while join_tx is low.
  function automatic join_mode_t join_decode(input logic jt, input logic jr);
    if (jt) begin
      return JOIN_TX;
    end else if (jr) begin
      return JOIN_RX;
    end
    return JOIN_NONE;
  endfunction

endpackage

// File: rtl/pio_fifo_mem.sv
// One circular buffer of 2*DEPTH entries whose usable capacity is chosen at runtime.
// Latency: a push is visible at head one cycle later; head is a combinational read.
// Backpressure: pushes on full are dropped unless a pull pops on the same edge; pulls on empty are ignored.
//
// Ports:
//   clk, reset   : clock and synchronous active-high reset
//   flush        : clear level and pointers, discarding push/pull on that edge
//   cap          : current capacity (0 .. 2*DEPTH); 0 disables the buffer
//   push, din    : write request and data
//   pull         : pop request
//   head         : entry at the read pointer (undefined when empty)
//   level        : current entry count
//   full, empty  : derived from level only
module pio_fifo_mem
  import pio_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int LVL_W = $clog2(2*DEPTH)+1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic [LVL_W-1:0] cap,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pull,
  output logic [WIDTH-1:0] head,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty
);

  localparam int ENTRIES = 2*DEPTH;
  localparam int PTR_W   = $clog2(ENTRIES);

  logic [WIDTH-1:0] mem [ENTRIES];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] cnt;
  logic             cap_zero;
  logic             do_push;
  logic             do_pull;

  assign cap_zero = (cap == '0);
  // A zero-capacity buffer looks both full and empty so nothing gets in or out.
  assign full     = cap_zero || (cnt == cap);
  assign empty    = (cnt == '0);
  assign level    = cnt;
  assign head     = mem[rd_ptr];

  // A full buffer always has at least one entry, so a same-edge pull frees the slot.
  assign do_pull = pull && !empty && !cap_zero && !flush;
  assign do_push = push && !cap_zero && !flush && (!full || do_pull);

  // Wrap at the runtime capacity, not at the physical array size.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p,
                                                input logic [LVL_W-1:0] c);
    logic [LVL_W-1:0] p1;
    p1 = LVL_W'(p) + LVL_W'(1);
    if (p1 >= c) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= next_ptr(wr_ptr, cap);
      end
      if (do_pull) begin
        rd_ptr <= next_ptr(rd_ptr, cap);
      end
      case ({do_push, do_pull})
        2'b10:   cnt <= cnt + LVL_W'(1);
        2'b01:   cnt <= cnt - LVL_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is never cleared; level gates what is visible.
  always_ff @(posedge clk) begin
    if (do_push && !reset) begin
      mem[wr_ptr] <= din;
    end
  end

endmodule

// File: rtl/pio_fifo_pair.sv
// TX (host->machine) and RX (machine->host) FIFO pair whose storage can be joined into one direction.
// Latency: push visible to reader next cycle; m_dout is fall-through, host_dout is registered on host_pull.
// Backpressure: full drops pushes (unless popped same edge), empty ignores pulls; a join change flushes both.
//
// Optional feature macro: PIO_FIFO_DEBUG_EN adds dbg_clr/dbg_flags sticky error flags.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   join_tx, join_rx           : storage join controls (join_tx wins)
//   host_push/host_din         : host write into TX
//   host_pull/host_dout        : host read from RX (registered, 0 when RX empty)
//   m_pull/m_dout              : machine read from TX (fall-through, 0 when TX empty)
//   m_push/m_din               : machine write into RX
//   tx_/rx_ full, empty, level : occupancy
//   status_sel/status_n/status_out : level-below-threshold compare
//   dbg_clr/dbg_flags          : {rxstall, rxunder, txover, txstall}, debug builds only
module pio_fifo_pair
  import pio_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int LVL_W = $clog2(2*DEPTH)+1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             join_tx,
  input  logic             join_rx,
  input  logic             host_push,
  input  logic [WIDTH-1:0] host_din,
  input  logic             host_pull,
  output logic [WIDTH-1:0] host_dout,
  input  logic             m_pull,
  output logic [WIDTH-1:0] m_dout,
  input  logic             m_push,
  input  logic [WIDTH-1:0] m_din,
  output logic             tx_full,
  output logic             tx_empty,
  output logic             rx_full,
  output logic             rx_empty,
  output logic [LVL_W-1:0] tx_level,
  output logic [LVL_W-1:0] rx_level,
  input  logic             status_sel,
  input  logic [LVL_W-1:0] status_n,
`ifdef PIO_FIFO_DEBUG_EN
  input  logic [3:0]       dbg_clr,
  output logic [3:0]       dbg_flags,
`endif
  output logic             status_out
);

  join_mode_t       join_q;
  join_mode_t       join_in;
  logic             flush;
  logic [LVL_W-1:0] tx_cap;
  logic [LVL_W-1:0] rx_cap;
  logic [WIDTH-1:0] tx_head;
  logic [WIDTH-1:0] rx_head;

  assign join_in = join_decode(join_tx, join_rx);
  // Any change of effective mode empties both sides before the new capacities apply.
  assign flush   = (join_in != join_q);

  always_comb begin
    tx_cap = LVL_W'(DEPTH);
    rx_cap = LVL_W'(DEPTH);
    case (join_q)
      JOIN_TX: begin
        tx_cap = LVL_W'(2*DEPTH);
        rx_cap = '0;
      end
      JOIN_RX: begin
        tx_cap = '0;
        rx_cap = LVL_W'(2*DEPTH);
      end
      default: begin
        tx_cap = LVL_W'(DEPTH);
        rx_cap = LVL_W'(DEPTH);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      join_q <= join_in;
    end else begin
      join_q <= join_in;
    end
  end

  pio_fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LVL_W(LVL_W)) u_tx (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .cap   (tx_cap),
    .push  (host_push),
    .din   (host_din),
    .pull  (m_pull),
    .head  (tx_head),
    .level (tx_level),
    .full  (tx_full),
    .empty (tx_empty)
  );

  pio_fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LVL_W(LVL_W)) u_rx (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .cap   (rx_cap),
    .push  (m_push),
    .din   (m_din),
    .pull  (host_pull),
    .head  (rx_head),
    .level (rx_level),
    .full  (rx_full),
    .empty (rx_empty)
  );

  assign m_dout = tx_empty ? '0 : tx_head;

  // Empty pulls return 0; a disabled RX leaves the last value in place.
  always_ff @(posedge clk) begin
    if (reset) begin
      host_dout <= '0;
    end else if (host_pull && !flush && (rx_cap != '0)) begin
      host_dout <= rx_empty ? '0 : rx_head;
    end
  end

  assign status_out = ((status_sel ? rx_level : tx_level) < status_n);

`ifdef PIO_FIFO_DEBUG_EN
  logic [3:0] dbg_set;
  logic       tx_pops;
  logic       rx_pops;

  // Mirror the buffers' acceptance rule to spot dropped pushes.
  assign tx_pops = m_pull && !tx_empty && (tx_cap != '0);
  assign rx_pops = host_pull && !rx_empty && (rx_cap != '0);

  always_comb begin
    dbg_set              = '0;
    dbg_set[DBG_TXOVER]  = host_push && tx_full && !tx_pops;
    dbg_set[DBG_TXSTALL] = m_pull && tx_empty;
    dbg_set[DBG_RXUNDER] = host_pull && rx_empty;
    dbg_set[DBG_RXSTALL] = m_push && rx_full && !rx_pops;
    // Traffic on a flush edge is discarded, not an error.
    if (flush) begin
      dbg_set = '0;
    end
  end

  // Clear beats set on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      dbg_flags <= '0;
    end else begin
      dbg_flags <= (dbg_flags | dbg_set) & ~dbg_clr;
    end
  end
`endif

endmodule

// File: tb/tb_pio_fifo_pair.sv
module tb_pio_fifo_pair;
  import pio_pkg::*;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int LVL_W = $clog2(2*DEPTH)+1;

  logic             clk = 1'b0;
  logic             reset;
  logic             join_tx, join_rx;
  logic             host_push, host_pull, m_pull, m_push;
  logic [WIDTH-1:0] host_din, m_din, host_dout, m_dout;
  logic             tx_full, tx_empty, rx_full, rx_empty;
  logic [LVL_W-1:0] tx_level, rx_level;
  logic             status_sel;
  logic [LVL_W-1:0] status_n;
  logic             status_out;
  logic [3:0]       dbg_clr;
  logic [3:0]       dbg_flags;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] tx_q[$];
  logic [WIDTH-1:0] rx_q[$];
  logic             hp_d = 1'b0;

  always #5 clk = ~clk;

  pio_fifo_pair #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .join_tx    (join_tx),
    .join_rx    (join_rx),
    .host_push  (host_push),
    .host_din   (host_din),
    .host_pull  (host_pull),
    .host_dout  (host_dout),
    .m_pull     (m_pull),
    .m_dout     (m_dout),
    .m_push     (m_push),
    .m_din      (m_din),
    .tx_full    (tx_full),
    .tx_empty   (tx_empty),
    .rx_full    (rx_full),
    .rx_empty   (rx_empty),
    .tx_level   (tx_level),
    .rx_level   (rx_level),
    .status_sel (status_sel),
    .status_n   (status_n),
`ifdef PIO_FIFO_DEBUG_EN
    .dbg_clr    (dbg_clr),
    .dbg_flags  (dbg_flags),
`endif
    .status_out (status_out)
  );

`ifndef PIO_FIFO_DEBUG_EN
  assign dbg_flags = 4'h0;
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Machine-side monitor: a pull on non-empty TX consumes the presented head.
  always @(negedge clk) begin
    if (!reset && m_pull && !tx_empty) begin
      if (tx_q.size() == 0) begin
        check("m_dout_unexpected", 64'(m_dout), 64'hDEAD_BEEF);
      end else begin
        check("m_dout", 64'(m_dout), 64'(tx_q.pop_front()));
      end
    end
  end

  // Host-side monitor: host_dout is compared on the half-cycle after each host_pull edge.
  always @(posedge clk) hp_d <= host_pull && !reset;
  always @(negedge clk) begin
    if (hp_d) begin
      if (rx_q.size() == 0) begin
        check("host_dout_unexpected", 64'(host_dout), 64'hDEAD_BEEF);
      end else begin
        check("host_dout", 64'(host_dout), 64'(rx_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_wr(input logic [WIDTH-1:0] d, input bit expect_out);
    host_push = 1'b1;
    host_din  = d;
    if (expect_out) tx_q.push_back(d);
    tick();
    host_push = 1'b0;
  endtask

  task automatic m_wr(input logic [WIDTH-1:0] d);
    m_push = 1'b1;
    m_din  = d;
    tick();
    m_push = 1'b0;
  endtask

  task automatic m_drain(input int n);
    m_pull = 1'b1;
    repeat (n) tick();
    m_pull = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; join_tx = 1'b0; join_rx = 1'b0;
    host_push = 1'b0; host_pull = 1'b0; m_pull = 1'b0; m_push = 1'b0;
    host_din = '0; m_din = '0; status_sel = 1'b0; status_n = '0; dbg_clr = 4'h0;
    tick(); tick();
    reset = 1'b0;

    // Reset state.
    check("rst_tx_level", 64'(tx_level), 64'd0);
    check("rst_tx_empty", 64'(tx_empty), 64'd1);
    check("rst_rx_empty", 64'(rx_empty), 64'd1);
    check("rst_tx_full",  64'(tx_full),  64'd0);
    check("rst_rx_full",  64'(rx_full),  64'd0);
    check("rst_host_dout", 64'(host_dout), 64'd0);
    check("rst_m_dout",   64'(m_dout),   64'd0);
    check("rst_dbg",      64'(dbg_flags), 64'd0);

    // TX overflow at DEPTH.
    host_wr(32'hA1, 1'b1);
    check("tx_vis_1cyc", 64'(m_dout), 64'hA1);
    host_wr(32'hA2, 1'b1);
    host_wr(32'hA3, 1'b1);
    check("tx_full_at3", 64'(tx_full), 64'd0);
    host_wr(32'hA4, 1'b1);
    check("tx_full_at4", 64'(tx_full), 64'd1);
    host_wr(32'hA5, 1'b0);
    check("tx_level_drop", 64'(tx_level), 64'd4);
    check("tx_head_A1", 64'(m_dout), 64'hA1);
`ifdef PIO_FIFO_DEBUG_EN
    check("dbg_txover", 64'(dbg_flags[DBG_TXOVER]), 64'd1);
`endif
    m_drain(4);
    check("tx_empty_drained", 64'(tx_empty), 64'd1);
    check("m_dout_empty0", 64'(m_dout), 64'd0);
    m_drain(1);
`ifdef PIO_FIFO_DEBUG_EN
    check("dbg_txstall", 64'(dbg_flags[DBG_TXSTALL]), 64'd1);
`endif
    dbg_clr = 4'hF; tick(); dbg_clr = 4'h0;
    check("dbg_cleared", 64'(dbg_flags), 64'd0);

    // RX full: simultaneous push and pull.
    m_wr(32'h11); m_wr(32'h22); m_wr(32'h33); m_wr(32'h44);
    check("rx_full_at4", 64'(rx_full), 64'd1);
    m_push = 1'b1; m_din = 32'h55; host_pull = 1'b1;
    rx_q.push_back(32'h11);
    tick();
    m_push = 1'b0; host_pull = 1'b0;
    check("rx_level_pp", 64'(rx_level), 64'd4);
`ifdef PIO_FIFO_DEBUG_EN
    check("dbg_no_rxstall", 64'(dbg_flags[DBG_RXSTALL]), 64'd0);
`endif
    rx_q.push_back(32'h22); rx_q.push_back(32'h33);
    rx_q.push_back(32'h44); rx_q.push_back(32'h55);
    host_pull = 1'b1; repeat (4) tick(); host_pull = 1'b0;
    check("rx_empty_drained", 64'(rx_empty), 64'd1);

    // RX underflow and clear-over-set.
    rx_q.push_back(32'h0);
    host_pull = 1'b1; tick(); host_pull = 1'b0;
`ifdef PIO_FIFO_DEBUG_EN
    check("dbg_rxunder", 64'(dbg_flags[DBG_RXUNDER]), 64'd1);
`endif
    rx_q.push_back(32'h0);
    host_pull = 1'b1; dbg_clr = 4'h0; dbg_clr[DBG_RXUNDER] = 1'b1;
    tick();
    host_pull = 1'b0; dbg_clr = 4'h0;
`ifdef PIO_FIFO_DEBUG_EN
    check("dbg_rxunder_clr", 64'(dbg_flags[DBG_RXUNDER]), 64'd0);
`endif

    // TX joined: capacity 2*DEPTH, RX disabled.
    join_tx = 1'b1; tick();
    check("jtx_rx_full",  64'(rx_full),  64'd1);
    check("jtx_rx_empty", 64'(rx_empty), 64'd1);
    for (int i = 0; i < 7; i++) host_wr(32'hB0 + i, 1'b1);
    check("jtx_full_at7", 64'(tx_full), 64'd0);
    host_wr(32'hB7, 1'b1);
    check("jtx_level8", 64'(tx_level), 64'd8);
    check("jtx_full_at8", 64'(tx_full), 64'd1);
    m_wr(32'h99);
    check("jtx_rx_level", 64'(rx_level), 64'd0);
    m_drain(8);
    host_wr(32'hC0, 1'b1);  // pointers have wrapped to 0
    m_drain(1);
    check("jtx_empty", 64'(tx_empty), 64'd1);

    // Join change flushes; status compare.
    join_tx = 1'b0; tick();
    host_wr(32'hD0, 1'b0); host_wr(32'hD1, 1'b0);
    check("tx_level2", 64'(tx_level), 64'd2);
    join_rx = 1'b1; tick();
    check("flush_tx_level", 64'(tx_level), 64'd0);
    check("flush_rx_level", 64'(rx_level), 64'd0);
    check("jrx_tx_full", 64'(tx_full), 64'd1);
    status_sel = 1'b0; status_n = LVL_W'(1); #1;
    check("status_tx_lt1", 64'(status_out), 64'd1);
    status_n = '0; #1;
    check("status_tx_lt0", 64'(status_out), 64'd0);
    for (int i = 0; i < 5; i++) m_wr(32'hE0 + i);
    check("jrx_level5", 64'(rx_level), 64'd5);
    check("jrx_not_full", 64'(rx_full), 64'd0);
    status_sel = 1'b1; status_n = LVL_W'(5); #1;
    check("status_rx_lt5", 64'(status_out), 64'd0);
    status_n = LVL_W'(6); #1;
    check("status_rx_lt6", 64'(status_out), 64'd1);

    // Reset mid-stream.
    join_rx = 1'b0; tick();
    m_wr(32'h77);
    rx_q.push_back(32'h77);
    host_pull = 1'b1; tick(); host_pull = 1'b0;
    host_wr(32'hF0, 1'b0); host_wr(32'hF1, 1'b0); host_wr(32'hF2, 1'b0);
    check("pre_rst_level3", 64'(tx_level), 64'd3);
    reset = 1'b1; host_push = 1'b1; host_din = 32'hFF;
    tick();
    reset = 1'b0; host_push = 1'b0;
    check("rst_mid_level", 64'(tx_level), 64'd0);
    check("rst_mid_empty", 64'(tx_empty), 64'd1);
    check("rst_mid_hdout", 64'(host_dout), 64'd0);

    tick(); tick();
    check("tx_q_consumed", 64'(tx_q.size()), 64'd0);
    check("rx_q_consumed", 64'(rx_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pio_fifo_pair.md
PIO_FIFO_PAIR -- requirements
Module: pio_fifo_pair

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width.
REQ-002 SHALL have parameter DEPTH, default 4, per-direction entries; a power of two and at least 2.
REQ-003 SHALL have parameter LVL_W, default $clog2(2*DEPTH)+1, level output width.
REQ-004 clk  in  1  sole clock; all state changes on rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 join_tx  in  1  give RX storage to TX (TX capacity 2*DEPTH).
REQ-007 join_rx  in  1  give TX storage to RX (RX capacity 2*DEPTH).
REQ-008 host_push  in  1 / host_din  in  WIDTH  host write into TX.
REQ-009 host_pull  in  1 / host_dout  out  WIDTH  host read from RX, registered.
REQ-010 m_pull  in  1 / m_dout  out  WIDTH  machine read from TX, first-word-fall-through.
REQ-011 m_push  in  1 / m_din  in  WIDTH  machine write into RX.
REQ-012 tx_full, tx_empty, rx_full, rx_empty  out  1 each  occupancy flags.
REQ-013 tx_level, rx_level  out  LVL_W each  current entry counts.
REQ-014 status_sel  in  1 / status_n  in  LVL_W / status_out  out  1  MOV STATUS source.
REQ-015 dbg_clr  in  4 / dbg_flags  out  4  sticky {rxstall, rxunder, txover, txstall}; present only with PIO_FIFO_DEBUG_EN.

Function
REQ-016 Capacity SHALL be: TX = RX = DEPTH when neither join is set; TX = 2*DEPTH and RX = 0 when join_tx is set; RX = 2*DEPTH and TX = 0 when only join_rx is set. join_rx SHALL be ignored while join_tx is set.
REQ-017 A direction with capacity 0 SHALL report full = 1, empty = 1 and level = 0, and SHALL ignore all pushes and pulls.
REQ-018 Any change of effective join mode SHALL flush both FIFOs (levels to 0, pointers to 0) on the next edge; pushes and pulls on that edge SHALL be discarded.
REQ-019 A push into a non-full FIFO SHALL be visible at the reader one cycle later.
REQ-020 m_dout SHALL equal the TX head entry when tx_empty = 0, and 0 when tx_empty = 1.
REQ-021 host_pull on a non-empty RX SHALL load the head into host_dout on that edge and pop it; on an empty RX it SHALL load 0.
REQ-022 A push into a full FIFO SHALL be dropped unless a pull occurs on the same edge; a simultaneous push and pull on a full FIFO SHALL both succeed with level unchanged.
REQ-023 A pull from an empty FIFO SHALL be ignored; a simultaneous push on the same edge SHALL be accepted, giving level 1.
REQ-024 Pointers SHALL wrap modulo capacity; level SHALL never exceed capacity or go below 0.
REQ-025 status_out SHALL be 1 iff (status_sel ? rx_level : tx_level) < status_n, combinationally.
REQ-026 Full and empty SHALL be derived from level only, never from pointer equality.

Reset
REQ-027 On reset, both levels and all pointers SHALL be 0, host_dout SHALL be 0, dbg_flags SHALL be 0 and the join mode register SHALL capture the current inputs. Consequently tx_empty = rx_empty = 1 and full = 0 for any non-zero-capacity direction.
REQ-028 Reset SHALL take priority over all push, pull and clear inputs; the storage contents need not be cleared.

Configuration
REQ-029 With PIO_FIFO_DEBUG_EN defined, each dbg_flags bit SHALL be sticky:
  - txover: set by host_push dropped on a full TX.
  - txstall: set by m_pull on an empty TX.
  - rxunder: set by host_pull on an empty RX.
  - rxstall: set by m_push dropped on a full RX.
  Each bit SHALL be cleared by the matching dbg_clr bit; a clear takes priority over a set on the same edge.
REQ-030 Without PIO_FIFO_DEBUG_EN, the dbg_clr and dbg_flags ports and their logic SHALL be absent, and behaviour SHALL be otherwise identical.

Structure
REQ-031 Package pio_pkg SHALL hold the join-mode enum (JOIN_NONE, JOIN_TX, JOIN_RX) and the debug-bit index constants.
REQ-032 A single sub-module, pio_fifo_mem, SHALL implement one circular buffer of 2*DEPTH entries with a runtime capacity input; it SHALL be instantiated twice.

Verification
REQ-033 DEPTH=4, no join: push 0xA1..0xA4 from the host, then a fifth push -> tx_full=1 after the fourth push, fifth push dropped, txover=1, m_dout=0xA1.
REQ-034 join_tx=1: push 8 words -> tx_level=8, tx_full only after the 8th; rx_full=rx_empty=1; m_push ignored.
REQ-035 RX full at 4: m_push 0x55 together with host_pull -> host_dout = old head, rx_level stays 4, 0x55 is the last entry.
REQ-036 RX empty: host_pull -> host_dout=0, rxunder=1; then dbg_clr[rxunder bit] together with a second empty pull -> flag reads 0.
REQ-037 TX level 2, toggle join_rx -> next cycle all levels 0; status_sel=0, status_n=1 -> status_out=1.
REQ-038 Reset asserted mid-stream with TX level 3 -> next cycle tx_level=0, tx_empty=1, host_dout=0.
